// File: rtl/ieee754_subtractor_mc.sv
// Multi-cycle IEEE754 single-precision subtractor (a - b), round-toward-zero,
// subnormals flushed to zero. One operation at a time through ALIGN/ADD/NORM.
module ieee754_subtractor_mc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [27:0] mant_p_q, mant_p_d, mant_s_q, mant_s_d;
    logic [8:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;

    // Operand decode from the captured copies.
    logic        a_sign, b_sign_eff;
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge_b;
    logic [7:0]  p_exp, s_exp, exp_diff;
    logic [4:0]  shamt;
    logic [27:0] p_mant, s_mant, s_shifted, s_mask;
    logic [27:0] sum;

    always_comb begin
        a_sign     = a_q[31];
        b_sign_eff = ~b_q[31];
        a_exp      = a_q[30:23];
        b_exp      = b_q[30:23];
        a_frac     = a_q[22:0];
        b_frac     = b_q[22:0];
        a_nan      = (a_exp == 8'hFF) && (a_frac != 23'd0);
        b_nan      = (b_exp == 8'hFF) && (b_frac != 23'd0);
        a_inf      = (a_exp == 8'hFF) && (a_frac == 23'd0);
        b_inf      = (b_exp == 8'hFF) && (b_frac == 23'd0);
        a_zero     = (a_exp == 8'd0);
        b_zero     = (b_exp == 8'd0);
        a_ge_b     = (a_q[30:0] >= b_q[30:0]);
        p_exp      = a_ge_b ? a_exp : b_exp;
        s_exp      = a_ge_b ? b_exp : a_exp;
        p_mant     = {2'b01, (a_ge_b ? a_frac : b_frac), 3'b000};
        s_mant     = {2'b01, (a_ge_b ? b_frac : a_frac), 3'b000};
        exp_diff   = p_exp - s_exp;
        shamt      = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        s_mask     = (28'd1 << shamt) - 28'd1;
        s_shifted  = s_mant >> shamt;
        // Everything shifted past the sticky position still counts toward sticky.
        s_shifted[0] = s_shifted[0] | (|(s_mant & s_mask));
        sum        = sub_q ? (mant_p_q - mant_s_q) : (mant_p_q + mant_s_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mant_p_d = mant_p_q;
        mant_s_d = mant_s_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = StAlign;
                end
            end
            StAlign: begin
                state_d = StDone;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                if (a_nan || b_nan) begin
                    result_d = 32'h7FC00000;
                end else if (a_inf && b_inf && (a_sign == b_q[31])) begin
                    result_d = 32'h7FC00000;
                end else if (a_inf) begin
                    result_d = a_q;
                end else if (b_inf) begin
                    result_d = {b_sign_eff, b_q[30:0]};
                end else if (a_zero && b_zero) begin
                    result_d = {a_sign & b_q[31] ^ a_sign & 1'b0 ? 1'b0 : (a_sign & ~b_q[31]), 31'd0};
                end else if (b_zero) begin
                    result_d = a_q;
                end else if (a_zero) begin
                    result_d = {b_sign_eff, b_q[30:0]};
                end else begin
                    state_d  = StAdd;
                    sign_d   = a_ge_b ? a_sign : b_sign_eff;
                    sub_d    = (a_sign != b_sign_eff);
                    exp_d    = {1'b0, p_exp};
                    mant_p_d = p_mant;
                    mant_s_d = s_shifted;
                end
            end
            StAdd: begin
                mant_p_d = sum;
                if (sum == 28'd0) begin
                    result_d = 32'h00000000;
                    state_d  = StDone;
                end else begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (mant_p_q[27]) begin
                    mant_p_d = {1'b0, mant_p_q[27:2], mant_p_q[1] | mant_p_q[0]};
                    exp_d    = exp_q + 9'd1;
                    state_d  = StDone;
                    if (exp_q + 9'd1 >= 9'd255) begin
                        result_d = {sign_q, 8'hFF, 23'd0};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_d[7:0], mant_p_d[25:3]};
                    end
                end else if (mant_p_q[26]) begin
                    state_d = StDone;
                    if (exp_q >= 9'd255) begin
                        result_d = {sign_q, 8'hFF, 23'd0};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_q[7:0], mant_p_q[25:3]};
                    end
                end else if (exp_q <= 9'd1) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    mant_p_d = {mant_p_q[26:0], 1'b0};
                    exp_d    = exp_q - 9'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            mant_p_q <= 28'd0;
            mant_s_q <= 28'd0;
            exp_q    <= 9'd0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mant_p_q <= mant_p_d;
            mant_s_q <= mant_s_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_ieee754_subtractor_mc.sv
// Directed-vector bench for ieee754_subtractor_mc: results, flags, latency,
// ignored start during NORM and asynchronous abort.
module tb_ieee754_subtractor_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, overflow, underflow;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_res;
    logic        got_ovf, got_unf;
    int          got_lat;

    ieee754_subtractor_mc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Start sampled at edge T0; got_lat = n means done was high just before edge Tn.
    task automatic run_op(input logic [31:0] a_v, input logic [31:0] b_v);
        @(negedge clk);
        a     = a_v;
        b     = b_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a       = $urandom;
        b       = $urandom;
        got_lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                got_lat = i;
                got_res = result;
                got_ovf = overflow;
                got_unf = underflow;
                break;
            end
        end
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic vec(input string tag, input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic [31:0] exp_res, input int exp_lat,
                       input logic exp_ovf, input logic exp_unf);
        run_op(a_v, b_v);
        check({tag, "_result"}, got_res, exp_res);
        check({tag, "_latency"}, got_lat, exp_lat);
        check({tag, "_overflow"}, {31'd0, got_ovf}, {31'd0, exp_ovf});
        check({tag, "_underflow"}, {31'd0, got_unf}, {31'd0, exp_unf});
    endtask

    initial begin
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {30'd0, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vec("three_minus_one", 32'h40400000, 32'h3F800000, 32'h40000000, 4, 1'b0, 1'b0);
        vec("one_minus_ulp",   32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 28, 1'b0, 1'b0);
        vec("exact_zero",      32'h3F800000, 32'h3F800000, 32'h00000000, 3, 1'b0, 1'b0);
        vec("neg_zero",        32'h80000000, 32'h00000000, 32'h80000000, 2, 1'b0, 1'b0);
        vec("inf_minus_inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 2, 1'b0, 1'b0);
        vec("overflow",        32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4, 1'b1, 1'b0);
        vec("sub_b_is_zero",   32'h00800000, 32'h00400000, 32'h00800000, 2, 1'b0, 1'b0);
        vec("underflow",       32'h00800001, 32'h00800000, 32'h00000000, 4, 1'b0, 1'b1);
        vec("nan_in",          32'h3F800000, 32'h7FC00001, 32'h7FC00000, 2, 1'b0, 1'b0);
        vec("zero_minus_b",    32'h00000000, 32'h40400000, 32'hC0400000, 2, 1'b0, 1'b0);
        vec("a_minus_neg_inf", 32'h3F800000, 32'hFF800000, 32'h7F800000, 2, 1'b0, 1'b0);
        // 1.0 - 3.0 = -2.0: b is primary, sign from inverted b.
        vec("one_minus_three", 32'h3F800000, 32'h40400000, 32'hC0000000, 4, 1'b0, 1'b0);
        // 1.5 + 1.5 = 3.0 via carry path.
        vec("carry_path",      32'h3FC00000, 32'hBFC00000, 32'h40400000, 4, 1'b0, 1'b0);

        // Start pulsed while NORM is looping must not disturb the pending result.
        fork
            vec("start_in_norm", 32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 28, 1'b0, 1'b0);
            begin
                repeat (10) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join

        // Asynchronous abort mid-NORM.
        @(negedge clk);
        a     = 32'h3F800000;
        b     = 32'h3F7FFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        begin
            int seen_done = 0;
            repeat (4) begin
                @(negedge clk);
                if (done) seen_done++;
            end
            check("abort_no_done", seen_done, 0);
        end
        rst_n = 1'b1;
        vec("after_abort", 32'h40400000, 32'h3F800000, 32'h40000000, 4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
